// File: rtl/axitrafficgen_dma_seq.sv
// rtl/axitrafficgen_dma_seq.sv - DMA read-then-write-back burst sequencer for the traffic generator.
// Reads each burst into a local beat buffer, then writes it to the region right after the source.
module axitrafficgen_dma_seq #(
    parameter int DATA_WIDTH = 64,
    parameter int BUF_DEPTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           conf_info_reg1,
    input  logic [31:0]           conf_info_reg2,
    input  logic                  conf_done,
    input  logic                  dma_read_ctrl_ready,
    output logic                  dma_read_ctrl_valid,
    output logic [31:0]           dma_read_ctrl_data_index,
    output logic [31:0]           dma_read_ctrl_data_length,
    output logic [2:0]            dma_read_ctrl_data_size,
    output logic                  dma_read_chnl_ready,
    input  logic                  dma_read_chnl_valid,
    input  logic [DATA_WIDTH-1:0] dma_read_chnl_data,
    input  logic                  dma_write_ctrl_ready,
    output logic                  dma_write_ctrl_valid,
    output logic [31:0]           dma_write_ctrl_data_index,
    output logic [31:0]           dma_write_ctrl_data_length,
    output logic [2:0]            dma_write_ctrl_data_size,
    input  logic                  dma_write_chnl_ready,
    output logic                  dma_write_chnl_valid,
    output logic [DATA_WIDTH-1:0] dma_write_chnl_data,
    output logic                  acc_done,
    output logic [31:0]           debug
);

    localparam int AW = $clog2(BUF_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RD_REQ  = 4'd1,
        S_RD_DATA = 4'd2,
        S_WR_REQ  = 4'd3,
        S_WR_DATA = 4'd4,
        S_DONE    = 4'd5
    } state_t;

    state_t                state;
    logic                  conf_done_q;
    logic [CNT_WIDTH-1:0]  len;
    logic [CNT_WIDTH-1:0]  nb;
    logic [31:0]           src;
    logic [31:0]           dst;
    logic [31:0]           acc;
    logic [CNT_WIDTH-1:0]  burst_k;
    logic [CNT_WIDTH-1:0]  beats_in;
    logic [CNT_WIDTH-1:0]  beats_out;
    logic [11:0]           bursts_done;
    logic [15:0]           beats_total;
    logic [DATA_WIDTH-1:0] beat_buf [BUF_DEPTH];

    logic                  start;
    logic [15:0]           cfg_len_raw;
    logic [15:0]           cfg_len;
    logic [15:0]           cfg_nb;
    logic [31:0]           cfg_span;
    logic [CNT_WIDTH-1:0]  len_last;
    logic [CNT_WIDTH-1:0]  nb_last;
    logic [CNT_WIDTH-1:0]  beats_out_nxt;

    assign start         = conf_done && !conf_done_q;
    assign cfg_len_raw   = conf_info_reg2[15:0];
    assign cfg_len       = (cfg_len_raw > 16'(BUF_DEPTH)) ? 16'(BUF_DEPTH) : cfg_len_raw;
    assign cfg_nb        = conf_info_reg2[31:16];
    // One-off product at start only; per-burst offsets use the running accumulator.
    assign cfg_span      = 32'(cfg_nb) * 32'(cfg_len);
    assign len_last      = len - CNT_WIDTH'(1);
    assign nb_last       = nb - CNT_WIDTH'(1);
    assign beats_out_nxt = beats_out + CNT_WIDTH'(1);

    assign dma_read_ctrl_data_size  = 3'b011;
    assign dma_write_ctrl_data_size = 3'b011;
    assign debug = {4'(state), bursts_done, beats_total};

    always_ff @(posedge clk) begin
        if (state == S_RD_DATA && dma_read_chnl_valid && dma_read_chnl_ready) begin
            beat_buf[beats_in[AW-1:0]] <= dma_read_chnl_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                      <= S_IDLE;
            conf_done_q                <= 1'b0;
            len                        <= '0;
            nb                         <= '0;
            src                        <= '0;
            dst                        <= '0;
            acc                        <= '0;
            burst_k                    <= '0;
            beats_in                   <= '0;
            beats_out                  <= '0;
            bursts_done                <= '0;
            beats_total                <= '0;
            dma_read_ctrl_valid        <= 1'b0;
            dma_read_ctrl_data_index   <= '0;
            dma_read_ctrl_data_length  <= '0;
            dma_read_chnl_ready        <= 1'b0;
            dma_write_ctrl_valid       <= 1'b0;
            dma_write_ctrl_data_index  <= '0;
            dma_write_ctrl_data_length <= '0;
            dma_write_chnl_valid       <= 1'b0;
            dma_write_chnl_data        <= '0;
            acc_done                   <= 1'b0;
        end else begin
            conf_done_q <= conf_done;
            acc_done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len         <= CNT_WIDTH'(cfg_len);
                        nb          <= CNT_WIDTH'(cfg_nb);
                        src         <= conf_info_reg1;
                        dst         <= conf_info_reg1 + cfg_span;
                        acc         <= '0;
                        burst_k     <= '0;
                        beats_in    <= '0;
                        beats_out   <= '0;
                        bursts_done <= '0;
                        beats_total <= '0;
                        state       <= (cfg_len == 16'd0 || cfg_nb == 16'd0) ? S_DONE : S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (!dma_read_ctrl_valid) begin
                        dma_read_ctrl_valid       <= 1'b1;
                        dma_read_ctrl_data_index  <= src + acc;
                        dma_read_ctrl_data_length <= 32'(len);
                    end else if (dma_read_ctrl_ready) begin
                        dma_read_ctrl_valid <= 1'b0;
                        dma_read_chnl_ready <= 1'b1;
                        state               <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (dma_read_chnl_valid && dma_read_chnl_ready) begin
                        beats_in <= beats_in + CNT_WIDTH'(1);
                        if (beats_in == len_last) begin
                            dma_read_chnl_ready <= 1'b0;
                            state               <= S_WR_REQ;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (!dma_write_ctrl_valid) begin
                        dma_write_ctrl_valid       <= 1'b1;
                        dma_write_ctrl_data_index  <= dst + acc;
                        dma_write_ctrl_data_length <= 32'(len);
                    end else if (dma_write_ctrl_ready) begin
                        dma_write_ctrl_valid <= 1'b0;
                        dma_write_chnl_valid <= 1'b1;
                        dma_write_chnl_data  <= beat_buf[0];
                        state                <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (dma_write_chnl_ready) begin
                        beats_total <= beats_total + 16'd1;
                        if (beats_out == len_last) begin
                            dma_write_chnl_valid <= 1'b0;
                            beats_in             <= '0;
                            beats_out            <= '0;
                            burst_k              <= burst_k + CNT_WIDTH'(1);
                            acc                  <= acc + 32'(len);
                            if (bursts_done != 12'hFFF) begin
                                bursts_done <= bursts_done + 12'd1;
                            end
                            state <= (burst_k == nb_last) ? S_DONE : S_RD_REQ;
                        end else begin
                            beats_out           <= beats_out_nxt;
                            dma_write_chnl_data <= beat_buf[beats_out_nxt[AW-1:0]];
                        end
                    end
                end
                S_DONE: begin
                    acc_done <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axitrafficgen_dma_seq.sv
// tb/tb_axitrafficgen_dma_seq.sv - scoreboard bench for the DMA burst sequencer.
module tb_axitrafficgen_dma_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] conf_info_reg1;
    logic [31:0] conf_info_reg2;
    logic        conf_done;
    logic        dma_read_ctrl_ready;
    logic        dma_read_ctrl_valid;
    logic [31:0] dma_read_ctrl_data_index;
    logic [31:0] dma_read_ctrl_data_length;
    logic [2:0]  dma_read_ctrl_data_size;
    logic        dma_read_chnl_ready;
    logic        dma_read_chnl_valid;
    logic [63:0] dma_read_chnl_data;
    logic        dma_write_ctrl_ready;
    logic        dma_write_ctrl_valid;
    logic [31:0] dma_write_ctrl_data_index;
    logic [31:0] dma_write_ctrl_data_length;
    logic [2:0]  dma_write_ctrl_data_size;
    logic        dma_write_chnl_ready;
    logic        dma_write_chnl_valid;
    logic [63:0] dma_write_chnl_data;
    logic        acc_done;
    logic [31:0] debug;

    axitrafficgen_dma_seq dut (
        .clk                        (clk),
        .rst                        (rst),
        .conf_info_reg1             (conf_info_reg1),
        .conf_info_reg2             (conf_info_reg2),
        .conf_done                  (conf_done),
        .dma_read_ctrl_ready        (dma_read_ctrl_ready),
        .dma_read_ctrl_valid        (dma_read_ctrl_valid),
        .dma_read_ctrl_data_index   (dma_read_ctrl_data_index),
        .dma_read_ctrl_data_length  (dma_read_ctrl_data_length),
        .dma_read_ctrl_data_size    (dma_read_ctrl_data_size),
        .dma_read_chnl_ready        (dma_read_chnl_ready),
        .dma_read_chnl_valid        (dma_read_chnl_valid),
        .dma_read_chnl_data         (dma_read_chnl_data),
        .dma_write_ctrl_ready       (dma_write_ctrl_ready),
        .dma_write_ctrl_valid       (dma_write_ctrl_valid),
        .dma_write_ctrl_data_index  (dma_write_ctrl_data_index),
        .dma_write_ctrl_data_length (dma_write_ctrl_data_length),
        .dma_write_ctrl_data_size   (dma_write_ctrl_data_size),
        .dma_write_chnl_ready       (dma_write_chnl_ready),
        .dma_write_chnl_valid       (dma_write_chnl_valid),
        .dma_write_chnl_data        (dma_write_chnl_data),
        .acc_done                   (acc_done),
        .debug                      (debug)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stall_pct = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int rdv_cycles = 0;
    int rd_first_cyc = 0;
    bit rd_first_arm = 0;
    int start_cyc = 0;
    logic [31:0] salt = 32'h0;

    logic [63:0] rd_exp[$];
    logic [63:0] wr_exp[$];
    logic [63:0] wq[$];
    int          rd_left = 0;
    logic [31:0] rd_next = 0;
    bit          rd_consumed = 0;
    bit          rc_pend = 0;
    bit          wc_pend = 0;
    logic [31:0] rc_idx, rc_len, wc_idx, wc_len;
    logic [27:0] exp_dbg;
    bit          exp_traffic;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit roll();
        return $urandom_range(99) >= stall_pct;
    endfunction

    function automatic logic [63:0] gen(input logic [31:0] idx);
        return {idx ^ salt, ~idx};
    endfunction

    // Handshake models for all four channels; inputs change on the falling edge.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (acc_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (dma_read_ctrl_valid) rdv_cycles++;

            if (rc_pend) begin
                check("rd_ctrl_hold", dma_read_ctrl_valid, 1);
                check("rd_idx_stable", dma_read_ctrl_data_index, rc_idx);
                check("rd_len_stable", dma_read_ctrl_data_length, rc_len);
            end
            dma_read_ctrl_ready = roll();
            rc_pend = 0;
            if (dma_read_ctrl_valid) begin
                if (rd_first_arm) begin
                    rd_first_cyc = cyc;
                    rd_first_arm = 0;
                end
                if (dma_read_ctrl_ready) begin
                    if (rd_exp.size() == 0) check("rd_ctrl_extra", 1, 0);
                    else begin
                        e = rd_exp.pop_front();
                        check("rd_idx", dma_read_ctrl_data_index, e[63:32]);
                        check("rd_len", dma_read_ctrl_data_length, e[31:0]);
                        check("rd_size", dma_read_ctrl_data_size, 3'b011);
                        check("rd_overlap", wq.size(), 0);
                    end
                    rd_left += int'(dma_read_ctrl_data_length);
                    rd_next = dma_read_ctrl_data_index;
                end else begin
                    rc_pend = 1;
                    rc_idx = dma_read_ctrl_data_index;
                    rc_len = dma_read_ctrl_data_length;
                end
            end

            if (rd_consumed) begin
                dma_read_chnl_valid = 1'b0;
                rd_consumed = 0;
            end
            if (!dma_read_chnl_valid && rd_left > 0 && roll()) begin
                dma_read_chnl_valid = 1'b1;
                dma_read_chnl_data = gen(rd_next);
            end
            if (dma_read_chnl_valid && dma_read_chnl_ready) begin
                wq.push_back(dma_read_chnl_data);
                rd_left--;
                rd_next++;
                rd_consumed = 1;
            end

            if (wc_pend) begin
                check("wr_ctrl_hold", dma_write_ctrl_valid, 1);
                check("wr_idx_stable", dma_write_ctrl_data_index, wc_idx);
                check("wr_len_stable", dma_write_ctrl_data_length, wc_len);
            end
            dma_write_ctrl_ready = roll();
            wc_pend = 0;
            if (dma_write_ctrl_valid) begin
                if (dma_write_ctrl_ready) begin
                    if (wr_exp.size() == 0) check("wr_ctrl_extra", 1, 0);
                    else begin
                        e = wr_exp.pop_front();
                        check("wr_idx", dma_write_ctrl_data_index, e[63:32]);
                        check("wr_len", dma_write_ctrl_data_length, e[31:0]);
                        check("wr_size", dma_write_ctrl_data_size, 3'b011);
                        check("wr_overlap", rd_left, 0);
                    end
                end else begin
                    wc_pend = 1;
                    wc_idx = dma_write_ctrl_data_index;
                    wc_len = dma_write_ctrl_data_length;
                end
            end

            dma_write_chnl_ready = roll();
            if (dma_write_chnl_valid && dma_write_chnl_ready) begin
                if (wq.size() == 0) check("wr_beat_extra", 1, 0);
                else check("wr_data", dma_write_chnl_data, wq.pop_front());
            end
        end
    end

    task automatic flush();
        rd_exp.delete();
        wr_exp.delete();
        wq.delete();
        rd_left = 0;
        rd_consumed = 0;
        rc_pend = 0;
        wc_pend = 0;
        dma_read_chnl_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] src, input logic [31:0] r2);
        logic [31:0] len, nb, dst;
        logic [11:0] bursts;
        len = (r2[15:0] > 16'd16) ? 32'd16 : {16'd0, r2[15:0]};
        nb  = {16'd0, r2[31:16]};
        dst = src + nb * len;
        exp_traffic = (len != 0) && (nb != 0);
        if (exp_traffic) begin
            for (int k = 0; k < int'(nb); k++) begin
                rd_exp.push_back({src + 32'(k) * len, len});
                wr_exp.push_back({dst + 32'(k) * len, len});
            end
        end
        bursts = !exp_traffic ? 12'd0 : (nb > 32'hFFF) ? 12'hFFF : nb[11:0];
        exp_dbg = exp_traffic ? {bursts, 16'(nb * len)} : 28'd0;
    endtask

    task automatic kick(input logic [31:0] src, input logic [31:0] r2);
        salt = salt + 32'h1357_9BDF;
        done_cnt = 0;
        rd_first_arm = 1;
        @(posedge clk);
        #2;
        conf_info_reg1 = src;
        conf_info_reg2 = r2;
        conf_done = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic run(input logic [31:0] src, input logic [31:0] r2, input bit hold);
        int rdv0;
        push_exp(src, r2);
        rdv0 = rdv_cycles;
        kick(src, r2);
        @(posedge clk);
        #2;
        if (!hold) conf_done = 1'b0;
        for (int i = 0; i < 20000 && done_cnt == 0; i++) @(posedge clk);
        check("done_timeout", done_cnt != 0, 1);
        repeat (3) @(posedge clk);
        #2;
        check("done_pulse_len", done_cnt, 1);
        check("rd_exp_left", rd_exp.size(), 0);
        check("wr_exp_left", wr_exp.size(), 0);
        check("wr_beats_left", wq.size(), 0);
        check("debug_cnt", debug[27:0], exp_dbg);
        check("debug_idle", debug[31:28], 0);
        if (exp_traffic) begin
            check("rd_valid_latency", rd_first_cyc - start_cyc, 2);
        end else begin
            check("no_traffic", rdv_cycles - rdv0, 0);
            check("done_latency", (done_cyc - start_cyc) <= 3, 1);
        end
    endtask

    initial begin
        int rdv0;
        bit reached;
        rst = 1'b1;
        conf_info_reg1 = '0;
        conf_info_reg2 = '0;
        conf_done = 1'b0;
        dma_read_ctrl_ready = 1'b0;
        dma_read_chnl_valid = 1'b0;
        dma_read_chnl_data = '0;
        dma_write_ctrl_ready = 1'b0;
        dma_write_chnl_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_rd_valid", dma_read_ctrl_valid, 0);
        check("rst_wr_valid", dma_write_ctrl_valid, 0);
        check("rst_wchnl_valid", dma_write_chnl_valid, 0);
        check("rst_rchnl_ready", dma_read_chnl_ready, 0);
        check("rst_done", acc_done, 0);
        check("rst_debug", debug, 0);
        check("rst_rd_size", dma_read_ctrl_data_size, 3'b011);
        check("rst_wr_size", dma_write_ctrl_data_size, 3'b011);
        rst = 1'b0;

        run(32'h100, 32'h0001_0004, 0);
        run(32'h100, 32'h0003_0002, 0);
        stall_pct = 50;
        run(32'h1000, 32'h0002_0008, 0);
        stall_pct = 30;
        run(32'h2000, 32'h0002_0014, 0);
        run(32'hFFFF_FFF8, 32'h0002_0004, 0);
        stall_pct = 0;
        run(32'h100, 32'h0000_0004, 0);
        run(32'h100, 32'h0005_0000, 0);

        // Abort during the second burst's write data, then restart cleanly.
        stall_pct = 20;
        push_exp(32'h200, 32'h0002_0004);
        kick(32'h200, 32'h0002_0004);
        @(posedge clk);
        #2;
        conf_done = 1'b0;
        reached = 0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            @(posedge clk);
            #2;
            reached = (debug[31:28] == 4'd4) && (debug[27:16] == 12'd1);
        end
        check("rst_reach_wr_data", reached, 1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        flush();
        check("midrst_rd_valid", dma_read_ctrl_valid, 0);
        check("midrst_wr_valid", dma_write_ctrl_valid, 0);
        check("midrst_wchnl_valid", dma_write_chnl_valid, 0);
        check("midrst_state", debug[31:28], 0);
        stall_pct = 0;
        run(32'h200, 32'h0002_0004, 0);

        // Level held high after completion must not retrigger.
        run(32'h300, 32'h0001_0003, 1);
        rdv0 = rdv_cycles;
        repeat (10) @(posedge clk);
        #2;
        check("hold_no_restart", rdv_cycles - rdv0, 0);
        check("hold_idle", debug[31:28], 0);
        check("hold_done_once", done_cnt, 1);
        conf_done = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
